reflet_mem_dma: RTL and testbench

//  Bus initiator for the single-port reflet RAM: copies LEN words from SRC to DST,
//  or fills LEN words at DST with a constant, without CPU involvement. Sits between
//  the control logic and a RAM instance, owning the RAM's enable/addr/data/write_en

---
 rtl/reflet_mem_dma.sv | 174 +++++++++++++++++
 tb/tb_reflet_mem_dma.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_mem_dma.sv
// reflet_mem_dma: copy/fill DMA initiator for the single-port reflet RAM.
// Drives the RAM enable/addr/data/write lines itself while a transfer is in flight.
module reflet_mem_dma #(
  parameter int addrSize = 7,
  parameter int wordsize = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [addrSize-1:0] src,
  input  logic [addrSize-1:0] dst,
  input  logic [addrSize:0]   len,
  input  logic [wordsize:0]   pattern,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                mem_enable,
  output logic [addrSize-1:0] mem_addr,
  output logic                mem_write_en,
  output logic [wordsize:0]   mem_wdata,
  input  logic [wordsize:0]   mem_rdata
);

  localparam int unsigned AW = addrSize;
  localparam int unsigned CW = addrSize + 1;
  localparam int unsigned DW = wordsize + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_FILL,
    S_FIN
  } state_t;

  state_t        state_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] idx_q;
  logic [DW-1:0] pat_q;
  logic [DW-1:0] hold_q;
  logic [AW-1:0] addr_q;
  logic          busy_q;
  logic          done_q;
  logic          en_q;
  logic          we_q;

  logic [CW-1:0] idx_inc;
  logic          last_word;
  logic [AW-1:0] src_nxt;
  logic [AW-1:0] dst_cur;
  logic [AW-1:0] dst_nxt;

  // Index/address arithmetic; addresses wrap at addrSize bits.
  always_comb begin
    idx_inc   = idx_q + CW'(1);
    last_word = (idx_inc == len_q);
    src_nxt   = src_q + idx_inc[AW-1:0];
    dst_cur   = dst_q + idx_q[AW-1:0];
    dst_nxt   = dst_q + idx_inc[AW-1:0];
  end

  // Control FSM; memory outputs are loaded together with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      hold_q  <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        en_q    <= 1'b0;
        we_q    <= 1'b0;
        addr_q  <= '0;
        hold_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              src_q  <= src;
              dst_q  <= dst;
              len_q  <= len;
              pat_q  <= pattern;
              idx_q  <= '0;
              busy_q <= 1'b1;
              if (len == '0) begin
                state_q <= S_FIN;
                done_q  <= 1'b1;
              end else if (!mode) begin
                state_q <= S_RD;
                en_q    <= 1'b1;
                addr_q  <= src;
              end else begin
                state_q <= S_FILL;
                en_q    <= 1'b1;
                we_q    <= 1'b1;
                addr_q  <= dst;
                hold_q  <= pattern;
              end
            end
          end
          S_RD: begin
            state_q <= S_CAP;
          end
          S_CAP: begin
            // hold_q doubles as the write-data register for the following WR.
            state_q <= S_WR;
            hold_q  <= mem_rdata;
            we_q    <= 1'b1;
            addr_q  <= dst_cur;
          end
          S_WR: begin
            idx_q <= idx_inc;
            we_q  <= 1'b0;
            if (last_word) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              en_q    <= 1'b0;
              addr_q  <= '0;
              hold_q  <= '0;
            end else begin
              state_q <= S_RD;
              addr_q  <= src_nxt;
            end
          end
          S_FILL: begin
            idx_q <= idx_inc;
            if (last_word) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              en_q    <= 1'b0;
              we_q    <= 1'b0;
              addr_q  <= '0;
              hold_q  <= '0;
            end else begin
              addr_q <= dst_nxt;
              hold_q <= pat_q;
            end
          end
          S_FIN: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Abort must suppress the write and the done pulse in the very cycle it is raised.
  assign busy         = busy_q;
  assign done         = done_q & ~abort;
  assign mem_enable   = en_q;
  assign mem_addr     = addr_q;
  assign mem_write_en = we_q & en_q & ~abort;
  assign mem_wdata    = hold_q;

endmodule

// File: tb/tb_reflet_mem_dma.sv
// Self-checking bench for reflet_mem_dma: RAM model, table of transfers with a
// word-level reference model, plus directed abort and reset sequences.
module tb_reflet_mem_dma;

  localparam int DEPTH = 128;

  typedef struct packed {
    logic            mode;
    logic [6:0]      src;
    logic [6:0]      dst;
    logic [7:0]      len;
    logic [8:0]      pattern;
    logic [15:0]     exp_cyc;
    logic [2:0]      pre_n;
    logic [3:0][8:0] pre_vals;
    logic            chk_en;
    logic [6:0]      chk_addr;
    logic [8:0]      chk_val;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [6:0] src;
  logic [6:0] dst;
  logic [7:0] len;
  logic [8:0] pattern;
  logic       abort;
  logic       busy;
  logic       done;
  logic       mem_enable;
  logic [6:0] mem_addr;
  logic       mem_write_en;
  logic [8:0] mem_wdata;
  logic [8:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [8:0] ram     [DEPTH];
  logic [8:0] ref_mem [DEPTH];
  logic [8:0] img     [DEPTH];
  logic       load_req = 1'b0;

  int en_cnt  = 0;
  int we_cnt  = 0;
  int bad_cnt = 0;

  always #5 clk = ~clk;

  reflet_mem_dma #(.addrSize(7), .wordsize(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .src          (src),
    .dst          (dst),
    .len          (len),
    .pattern      (pattern),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .mem_enable   (mem_enable),
    .mem_addr     (mem_addr),
    .mem_write_en (mem_write_en),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Single-port RAM, read data one cycle after the address.
  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < DEPTH; k++) ram[k] <= img[k];
    end else if (mem_enable) begin
      if (mem_write_en) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_enable) en_cnt++;
    if (mem_write_en) we_cnt++;
    if (mem_write_en && !mem_enable) bad_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_ram();
    for (int k = 0; k < DEPTH; k++) img[k] = ref_mem[k];
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic compare_ram(input string name);
    int mism;
    int first;
    mism  = 0;
    first = -1;
    for (int k = 0; k < DEPTH; k++) begin
      if (ram[k] !== ref_mem[k]) begin
        mism++;
        if (first < 0) first = k;
      end
    end
    if (mism != 0) $display("  first differing word at address %0d", first);
    check(name, mism, 0);
  endtask

  // Reference: words move one at a time in ascending order, addresses wrap.
  task automatic model_words(input logic m, input int s, input int d, input int n, input int p);
    for (int k = 0; k < n; k++) begin
      if (m) ref_mem[(d + k) & 127] = 9'(p);
      else   ref_mem[(d + k) & 127] = ref_mem[(s + k) & 127];
    end
  endtask

  function automatic int exp_latency(input logic m, input int l);
    if (l == 0) return 1;
    return m ? l + 1 : 3 * l + 1;
  endfunction

  function automatic vec_t mk(input logic m, input int s, input int d, input int l,
                              input int p, input int e);
    vec_t v;
    v = '0;
    v.mode    = m;
    v.src     = 7'(s);
    v.dst     = 7'(d);
    v.len     = 8'(l);
    v.pattern = 9'(p);
    v.exp_cyc = 16'(e);
    return v;
  endfunction

  task automatic start_xfer(input logic m, input int s, input int d, input int l, input int p);
    mode    = m;
    src     = 7'(s);
    dst     = 7'(d);
    len     = 8'(l);
    pattern = 9'(p);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  cyc;
    int  busy_n;
    int  en0;
    int  we0;
    bit  seen;
    if (v.pre_n != 0) begin
      for (int k = 0; k < int'(v.pre_n); k++) ref_mem[(int'(v.src) + k) & 127] = v.pre_vals[k];
      load_ram();
    end
    en0 = en_cnt;
    we0 = we_cnt;
    start_xfer(v.mode, int'(v.src), int'(v.dst), int'(v.len), int'(v.pattern));
    cyc    = 1;
    busy_n = 0;
    seen   = 1'b0;
    while (cyc <= 1000) begin
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      cyc++;
      @(negedge clk);
    end
    check("done_seen", int'(seen), 1);
    check("done_cycle", cyc, int'(v.exp_cyc));
    check("busy_cycles", busy_n, int'(v.exp_cyc));
    @(negedge clk);
    check("idle_after", int'({busy, done}), 0);
    check("en_cycles", en_cnt - en0, v.mode ? int'(v.len) : 3 * int'(v.len));
    check("we_cycles", we_cnt - we0, int'(v.len));
    model_words(v.mode, int'(v.src), int'(v.dst), int'(v.len), int'(v.pattern));
    compare_ram("ram");
    if (v.chk_en) check("word", int'(ram[v.chk_addr]), int'(v.chk_val));
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    int   dn;

    reset   = 1'b0;
    start   = 1'b0;
    mode    = 1'b0;
    src     = '0;
    dst     = '0;
    len     = '0;
    pattern = '0;
    abort   = 1'b0;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 9'($urandom_range(0, 511));

    repeat (2) @(negedge clk);
    check("reset_outputs", int'({busy, done, mem_enable, mem_write_en, mem_addr, mem_wdata}), 0);
    reset = 1'b1;
    load_ram();

    v = mk(1'b0, 0, 16, 4, 0, 13);
    v.pre_n = 3'd4;
    v.pre_vals[0] = 9'd11; v.pre_vals[1] = 9'd22; v.pre_vals[2] = 9'd33; v.pre_vals[3] = 9'd44;
    v.chk_en = 1'b1; v.chk_addr = 7'd19; v.chk_val = 9'd44;
    vecs.push_back(v);
    v = mk(1'b1, 0, 120, 16, 'h1A5, 17);
    v.chk_en = 1'b1; v.chk_addr = 7'd7; v.chk_val = 9'h1A5;
    vecs.push_back(v);
    vecs.push_back(mk(1'b0, 5, 9, 0, 0, 1));
    vecs.push_back(mk(1'b1, 5, 9, 0, 'h0FF, 1));
    v = mk(1'b0, 0, 1, 3, 0, 10);
    v.pre_n = 3'd4;
    v.pre_vals[0] = 9'd5; v.pre_vals[1] = 9'd6; v.pre_vals[2] = 9'd7; v.pre_vals[3] = 9'd8;
    v.chk_en = 1'b1; v.chk_addr = 7'd3; v.chk_val = 9'd5;
    vecs.push_back(v);
    vecs.push_back(mk(1'b0, 120, 124, 10, 0, 31));
    vecs.push_back(mk(1'b1, 3, 3, 128, 'h155, 129));
    for (int r = 0; r < 20; r++) begin
      int m;
      int l;
      m = int'($urandom_range(0, 1));
      l = int'($urandom_range(0, 24));
      vecs.push_back(mk(1'(m), int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), l,
                        int'($urandom_range(0, 511)), exp_latency(1'(m), l)));
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort an 8-word copy during the read of word 2.
    start_xfer(1'b0, 0, 64, 8, 0);
    dn = 0;
    for (int c = 1; c < 7; c++) begin
      if (done) dn++;
      @(negedge clk);
    end
    abort = 1'b1;
    if (done) dn++;
    @(negedge clk);
    abort = 1'b0;
    check("abort_copy_busy", int'(busy), 0);
    check("abort_copy_done", dn + int'(done), 0);
    model_words(1'b0, 0, 64, 2, 0);
    compare_ram("abort_copy_ram");
    run_vec(mk(1'b0, 30, 90, 5, 0, 16));

    // Abort a fill during the write of word 3: that write must not land.
    start_xfer(1'b1, 0, 100, 10, 'h0A3);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_fill_busy", int'(busy), 0);
    model_words(1'b1, 0, 100, 3, 'h0A3);
    compare_ram("abort_fill_ram");

    // Start together with abort in idle is ignored.
    abort = 1'b1;
    start_xfer(1'b1, 0, 20, 4, 'h111);
    abort = 1'b0;
    check("abort_start_busy", int'(busy), 0);
    @(negedge clk);
    check("abort_start_busy2", int'(busy), 0);
    compare_ram("abort_start_ram");

    // Reset mid-fill: five words landed, outputs clear without a clock edge.
    start_xfer(1'b1, 0, 40, 16, 'h0C7);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_async", int'({busy, done, mem_enable, mem_write_en, mem_addr, mem_wdata}), 0);
    @(negedge clk);
    reset = 1'b1;
    model_words(1'b1, 0, 40, 5, 'h0C7);
    compare_ram("reset_fill_ram");
    run_vec(mk(1'b1, 0, 60, 6, 'h02D, 7));

    check("we_without_en", bad_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
